// File: rtl/pcie_tx_rdylat_bridge.sv
// pcie_tx_rdylat_bridge: buffers FIM TX beats and issues them to the HIP
// only in cycles allowed by its fixed ready latency; reports outbound MRds.
// Ports: avl_clk, avl_rst (sync, active-high)
//   in_valid/in_ready/in_data/in_sop/in_eop : upstream AVST sink
//   avl_tx_ready/valid/data/sop/eop         : HIP TX AVST source
//   tx_mrd_valid/tag/length                 : one-cycle MRd report
//   pkt_err                                 : sticky upstream framing error
module pcie_tx_rdylat_bridge #(
   parameter int DATA_W        = 256,
   parameter int DEPTH_LOG2    = 5,
   parameter int READY_LATENCY = 3,
   parameter int TAG_W         = 8
) (
   input  logic              avl_clk,
   input  logic              avl_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic              avl_tx_ready,
   output logic              avl_tx_valid,
   output logic [DATA_W-1:0] avl_tx_data,
   output logic              avl_tx_sop,
   output logic              avl_tx_eop,
   output logic              tx_mrd_valid,
   output logic [TAG_W-1:0]  tx_mrd_tag,
   output logic [10:0]       tx_mrd_length,
   output logic              pkt_err
);

   localparam int BW = DATA_W + 2;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

   typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

   logic [BW-1:0]         mem_q [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  wr_en, rd_en, empty, rdy_ok;
   logic [BW-1:0]         head;

   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_W-1:0]     tx_data_q, tx_data_d;
   logic                  tx_sop_q, tx_sop_d;
   logic                  tx_eop_q, tx_eop_d;

   logic                  mrd_valid_q, mrd_valid_d;
   logic [TAG_W-1:0]      mrd_tag_q, mrd_tag_d;
   logic [10:0]           mrd_len_q, mrd_len_d;
   logic                  is_mrd;

   state_t                state_q, state_d;
   logic                  err_set;
   logic                  pkt_err_q, pkt_err_d;

   // Full exactly when the occupancy MSB is set (count == depth).
   assign in_ready = ~avl_rst & ~count_q[DEPTH_LOG2];
   assign wr_en    = in_valid & in_ready;
   assign empty    = (count_q == '0);
   assign rd_en    = rdy_ok & ~empty;
   assign head     = mem_q[rd_ptr_q];

   // Ready window: avl_tx_ready delayed by READY_LATENCY-1 cycles.
   generate
      if (READY_LATENCY == 1) begin : g_rl1
         assign rdy_ok = avl_tx_ready;
      end else begin : g_rlsr
         logic [READY_LATENCY-2:0] rdy_sr_q, rdy_sr_d;
         always_comb begin
            rdy_sr_d    = rdy_sr_q << 1;
            rdy_sr_d[0] = avl_tx_ready;
         end
         always_ff @(posedge avl_clk) begin
            if (avl_rst) rdy_sr_q <= '0;
            else         rdy_sr_q <= rdy_sr_d;
         end
         assign rdy_ok = rdy_sr_q[READY_LATENCY-2];
      end
   endgenerate

   always_ff @(posedge avl_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {in_sop, in_eop, in_data};
   end

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Output stage: head beat registered on the read edge; holds when idle.
   always_comb begin
      tx_valid_d = rd_en;
      tx_data_d  = tx_data_q;
      tx_sop_d   = tx_sop_q;
      tx_eop_d   = tx_eop_q;
      if (rd_en) begin
         tx_sop_d  = head[BW-1];
         tx_eop_d  = head[BW-2];
         tx_data_d = head[DATA_W-1:0];
      end
   end

   // MRd: fmt 000/001 with type 00000, seen on an issued SOP beat.
   assign is_mrd = tx_valid_q & tx_sop_q
                 & (tx_data_q[31:30] == 2'b00)
                 & (tx_data_q[28:24] == 5'b00000);

   always_comb begin
      mrd_valid_d = is_mrd;
      mrd_tag_d   = mrd_tag_q;
      mrd_len_d   = mrd_len_q;
      if (is_mrd) begin
         mrd_tag_d = TAG_W'(tx_data_q[47:40]);
         mrd_len_d = (tx_data_q[9:0] == 10'd0) ? 11'd1024
                                               : {1'b0, tx_data_q[9:0]};
      end
   end

   // Framing tracker: state register.
   always_ff @(posedge avl_clk) begin
      if (avl_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Framing tracker: next state. A SOP always restarts the packet.
   always_comb begin
      state_d = state_q;
      if (wr_en) begin
         unique case (state_q)
            IDLE:    if (in_sop & ~in_eop) state_d = IN_PKT;
            IN_PKT:  if (in_eop)           state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Framing tracker: error output.
   always_comb begin
      err_set = 1'b0;
      if (wr_en) begin
         unique case (state_q)
            IDLE:    err_set = ~in_sop;
            IN_PKT:  err_set = in_sop;
            default: err_set = 1'b0;
         endcase
      end
      pkt_err_d = pkt_err_q | err_set;
   end

   always_ff @(posedge avl_clk) begin
      if (avl_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         tx_sop_q    <= 1'b0;
         tx_eop_q    <= 1'b0;
         mrd_valid_q <= 1'b0;
         mrd_tag_q   <= '0;
         mrd_len_q   <= '0;
         pkt_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         tx_sop_q    <= tx_sop_d;
         tx_eop_q    <= tx_eop_d;
         mrd_valid_q <= mrd_valid_d;
         mrd_tag_q   <= mrd_tag_d;
         mrd_len_q   <= mrd_len_d;
         pkt_err_q   <= pkt_err_d;
      end
   end

   assign avl_tx_valid  = tx_valid_q;
   assign avl_tx_data   = tx_data_q;
   assign avl_tx_sop    = tx_sop_q;
   assign avl_tx_eop    = tx_eop_q;
   assign tx_mrd_valid  = mrd_valid_q;
   assign tx_mrd_tag    = mrd_tag_q;
   assign tx_mrd_length = mrd_len_q;
   assign pkt_err       = pkt_err_q;

endmodule

// File: doc/pcie_tx_rdylat_bridge.md
Name: pcie_tx_rdylat_bridge

Overview:
TX-direction counterpart of the RX ingress path. Buffers TLP beats from the FIM-side TX stream and drives the PCIe HIP TX AVST port. Beats are issued only in cycles permitted by the HIP's fixed ready latency. The block also detects outbound MRd headers and reports tag and length to the completion-timeout and credit tracking logic.

Parameters:
DATA_W, 256, TX AVST data width in bits; minimum 64.
DEPTH_LOG2, 5, log2 of the beat buffer depth; buffer holds 2**DEPTH_LOG2 beats.
READY_LATENCY, 3, HIP TX ready latency in cycles; legal range 1..8.
TAG_W, 8, MRd tag width.

Ports:
avl_clk  in  1  clock for all logic.
avl_rst  in  1  reset; synchronous, active-high.
in_valid  in  1  upstream beat valid.
in_ready  out  1  upstream ready; a beat transfers when in_valid & in_ready.
in_data  in  DATA_W  beat data; DW0 in [31:0], DW1 in [63:32].
in_sop  in  1  first beat of TLP.
in_eop  in  1  last beat of TLP.
avl_tx_ready  in  1  HIP ready, subject to READY_LATENCY.
avl_tx_valid  out  1  beat valid to HIP.
avl_tx_data  out  DATA_W  beat data to HIP.
avl_tx_sop  out  1  SOP to HIP.
avl_tx_eop  out  1  EOP to HIP.
tx_mrd_valid  out  1  one-cycle pulse per MRd issued.
tx_mrd_tag  out  TAG_W  tag of the reported MRd.
tx_mrd_length  out  11  MRd length in DW, range 1..1024.
pkt_err  out  1  sticky upstream framing error.

Behaviour:
- Reset (avl_rst=1 at a clock edge):
  - Buffer flushed, ready delay line cleared, framing state set to IDLE.
  - All outputs 0 from the next cycle, including in_ready, pkt_err and tx_mrd_*.
  - Reset mid-packet discards partial TLPs. After reset, the first legal upstream beat is a SOP.
- in_ready = ~avl_rst & (occupancy < 2**DEPTH_LOG2). It is combinational from registered occupancy and never depends on in_valid.
- Buffer:
  - Fall-through FIFO; occupancy counter width DEPTH_LOG2+1.
  - A simultaneous write and read leaves occupancy unchanged.
  - A read from an empty buffer never occurs.
  - The write at full is blocked by in_ready; no overflow path exists.
- Ready window:
  - rdy_sr is a shift register of avl_tx_ready of length READY_LATENCY-1.
  - rdy_ok = avl_tx_ready delayed by READY_LATENCY-1 cycles; for READY_LATENCY=1, rdy_ok = avl_tx_ready.
  - A read occurs in cycle t iff rdy_ok & ~empty.
  - The head beat is registered onto avl_tx_* at the t edge, so it is visible in cycle t+1.
- Output invariant: avl_tx_valid=1 in cycle t only if avl_tx_ready=1 in cycle t-READY_LATENCY.
  - avl_tx_valid=0 in any cycle without a read in the previous cycle.
  - avl_tx_data/sop/eop hold their last values when valid=0.
- Latency: a beat accepted in cycle t, with an empty buffer and ready continuously high, appears on avl_tx_valid in cycle t+2.
- Beats leave in order with no reordering, duplication or drop. A TLP may be split across ready gaps.
- Framing tracker on upstream accepted beats; states IDLE and IN_PKT:
  - IDLE, sop & eop → IDLE.
  - IDLE, sop & ~eop → IN_PKT.
  - IDLE, ~sop → set pkt_err; state unchanged.
  - IN_PKT, sop → set pkt_err; treat as new SOP.
  - IN_PKT, eop → IDLE.
  - Beats are forwarded regardless of pkt_err.
  - pkt_err clears only on reset.
- MRd detect, evaluated on each output beat with avl_tx_valid & avl_tx_sop:
  - Condition: fmt = data[31:29] is 000 or 001, and type = data[28:24] = 00000.
  - tx_mrd_valid pulses in the following cycle.
  - tx_mrd_tag = data[32+15:32+8] (DW1[15:8]), zero-extended or truncated to TAG_W.
  - tx_mrd_length = data[9:0]; a value of 0 encodes 1024.
  - tx_mrd_tag/length hold until the next pulse.
  - MRd on back-to-back SOP beats gives back-to-back pulses.
  - MWr, Cpl and MRdLk (type 00001) give no pulse.

Test Plan:
1. Ready latency: READY_LATENCY=3, buffer preloaded with 4 single-beat TLPs, avl_tx_ready high for cycles 10-11 only → avl_tx_valid high exactly in cycles 13-14, beats 0 and 1; beats 2-3 remain buffered.
2. Backpressure/full: DEPTH_LOG2=5, avl_tx_ready=0, in_valid held high → exactly 32 beats accepted and in_ready=0 from the cycle after the 32nd. Then ready=1 → all 32 beats out in order, and in_ready returns to 1 the cycle after the first read.
3. Latency/throughput: empty buffer, ready constantly 1, 8-beat TLP streamed → first beat valid 2 cycles after acceptance; 8 consecutive valid cycles; sop on beat 0 only, eop on beat 7 only.
4. MRd report: SOP beat with DW0=0x0000_0000 (MRd32, len 0) and DW1[15:8]=0xA5 → tx_mrd_valid one cycle after the SOP output beat, tag 0xA5, length 1024. Second MRd with len=0x010 → length 16.
5. Non-MRd: MWr (fmt 010) and Cpl (type 01010) SOP beats → tx_mrd_valid stays 0.
6. Framing error and reset: beat without sop in IDLE → pkt_err=1 next cycle and beat still forwarded. Then assert avl_rst mid-packet with 5 beats buffered → next cycle avl_tx_valid=0, in_ready=0, pkt_err=0; after reset deasserts, no stale beats emerge.
